// File: rtl/link_table_order_arbiter.sv
// -----------------------------------------------------------------------------
// link_table_order_arbiter
//
// Shares the single order/result port of one link-table manager between
// NUM_REQ client front-ends. Grants are round-robin. Only one order is in
// flight at a time. The manager's result is routed back to the requester that
// issued the order. A watchdog aborts an order that the manager leaves
// unanswered for TIMEOUT_CYCLES cycles and returns a timeout response instead.
// The manager's RAM port is not touched by this block.
//
// Ports
//   clk, rst_n         clock; asynchronous active-low reset
//   req_valid/busy     per-requester order handshake (xfer = valid && !busy)
//   req_type           packed 2 bits per requester: 00 APPE, 01 DELE, 10 CHAG, 11 READ
//   req_table          packed TABLE_WIDTH bits per requester
//   req_node           packed ADDR_WIDTH bits per requester
//   req_data           packed DATA_WIDTH bits per requester
//   rsp_valid          one-hot result valid; only the granted requester is set
//   rsp_busy           per-requester result backpressure
//   rsp_data           shared result data bus
//   rsp_timeout        1 when the result is a watchdog abort
//   mgr_order_*        latched order towards the manager
//   mgr_order_busy     manager order backpressure
//   mgr_dout_valid     manager result valid
//   mgr_dout_busy      backpressure towards the manager result port
//   mgr_dout_data      manager result data
// -----------------------------------------------------------------------------
module link_table_order_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int TABLE_WIDTH    = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,

    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_busy,
    input  logic [2*NUM_REQ-1:0]           req_type,
    input  logic [TABLE_WIDTH*NUM_REQ-1:0] req_table,
    input  logic [ADDR_WIDTH*NUM_REQ-1:0]  req_node,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]  req_data,

    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_busy,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           rsp_timeout,

    output logic                           mgr_order_valid,
    input  logic                           mgr_order_busy,
    output logic [1:0]                     mgr_order_type,
    output logic [TABLE_WIDTH-1:0]         mgr_order_table,
    output logic [ADDR_WIDTH-1:0]          mgr_order_node,
    output logic [DATA_WIDTH-1:0]          mgr_order_data,

    input  logic                           mgr_dout_valid,
    output logic                           mgr_dout_busy,
    input  logic [DATA_WIDTH-1:0]          mgr_dout_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state, state_n;

    logic [IDX_W-1:0]       rr_ptr,  rr_ptr_n;
    logic [IDX_W-1:0]       gnt_idx, gnt_idx_n;
    logic [WD_W-1:0]        wd_cnt,  wd_cnt_n;

    logic                   order_valid_n;
    logic [1:0]             order_type_n;
    logic [TABLE_WIDTH-1:0] order_table_n;
    logic [ADDR_WIDTH-1:0]  order_node_n;
    logic [DATA_WIDTH-1:0]  order_data_n;

    logic [NUM_REQ-1:0]     rsp_valid_n;
    logic [DATA_WIDTH-1:0]  rsp_data_n;
    logic                   rsp_timeout_n;

    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;
    logic                   wd_expire;
    logic [IDX_W-1:0]       gnt_next_ptr;

    // -------------------------------------------------------------------------
    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    // -------------------------------------------------------------------------
    always_comb begin : grant_search
        int cand;
        // NOTE: every signal written here gets a default before any branch so
        // no path leaves it unassigned and no latch is inferred.
        cand       = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!pick_found && req_valid[IDX_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    // Only the requester about to be granted sees its order accepted.
    always_comb begin
        req_busy = '1;
        if (state == S_IDLE && pick_found) begin
            req_busy[pick_idx] = 1'b0;
        end
    end

    // Results are accepted in WAIT; in IDLE a stray result is swallowed so a
    // late answer to an aborted order cannot stall the manager.
    assign mgr_dout_busy = !(state == S_IDLE || state == S_WAIT);

    assign wd_expire    = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign gnt_next_ptr = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_n       = state;
        rr_ptr_n      = rr_ptr;
        gnt_idx_n     = gnt_idx;
        wd_cnt_n      = wd_cnt;
        order_valid_n = mgr_order_valid;
        order_type_n  = mgr_order_type;
        order_table_n = mgr_order_table;
        order_node_n  = mgr_order_node;
        order_data_n  = mgr_order_data;
        rsp_valid_n   = rsp_valid;
        rsp_data_n    = rsp_data;
        rsp_timeout_n = rsp_timeout;

        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    gnt_idx_n     = pick_idx;
                    order_type_n  = req_type [int'(pick_idx)*2           +: 2];
                    order_table_n = req_table[int'(pick_idx)*TABLE_WIDTH +: TABLE_WIDTH];
                    order_node_n  = req_node [int'(pick_idx)*ADDR_WIDTH  +: ADDR_WIDTH];
                    order_data_n  = req_data [int'(pick_idx)*DATA_WIDTH  +: DATA_WIDTH];
                    order_valid_n = 1'b1;
                    wd_cnt_n      = '0;
                    state_n       = S_ISSUE;
                end
            end

            S_ISSUE: begin
                wd_cnt_n = wd_cnt + 1'b1;
                if (wd_expire) begin
                    order_valid_n        = 1'b0;
                    rsp_data_n           = '0;
                    rsp_timeout_n        = 1'b1;
                    rsp_valid_n          = '0;
                    rsp_valid_n[gnt_idx] = 1'b1;
                    state_n              = S_RESP;
                end else if (!mgr_order_busy) begin
                    order_valid_n = 1'b0;
                    state_n       = S_WAIT;
                end
            end

            S_WAIT: begin
                wd_cnt_n = wd_cnt + 1'b1;
                // A manager answer in the expiry cycle still counts as a
                // normal response.
                if (mgr_dout_valid) begin
                    rsp_data_n           = mgr_dout_data;
                    rsp_timeout_n        = 1'b0;
                    rsp_valid_n          = '0;
                    rsp_valid_n[gnt_idx] = 1'b1;
                    state_n              = S_RESP;
                end else if (wd_expire) begin
                    order_valid_n        = 1'b0;
                    rsp_data_n           = '0;
                    rsp_timeout_n        = 1'b1;
                    rsp_valid_n          = '0;
                    rsp_valid_n[gnt_idx] = 1'b1;
                    state_n              = S_RESP;
                end
            end

            S_RESP: begin
                // Backpressure from requesters that were not granted is ignored.
                if (!rsp_busy[gnt_idx]) begin
                    rsp_valid_n = '0;
                    rr_ptr_n    = gnt_next_ptr;
                    state_n     = S_IDLE;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            rr_ptr          <= '0;
            gnt_idx         <= '0;
            wd_cnt          <= '0;
            mgr_order_valid <= 1'b0;
            mgr_order_type  <= '0;
            mgr_order_table <= '0;
            mgr_order_node  <= '0;
            mgr_order_data  <= '0;
            rsp_valid       <= '0;
            rsp_data        <= '0;
            rsp_timeout     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the values computed for this edge, independent of statement order.
            state           <= state_n;
            rr_ptr          <= rr_ptr_n;
            gnt_idx         <= gnt_idx_n;
            wd_cnt          <= wd_cnt_n;
            mgr_order_valid <= order_valid_n;
            mgr_order_type  <= order_type_n;
            mgr_order_table <= order_table_n;
            mgr_order_node  <= order_node_n;
            mgr_order_data  <= order_data_n;
            rsp_valid       <= rsp_valid_n;
            rsp_data        <= rsp_data_n;
            rsp_timeout     <= rsp_timeout_n;
        end
    end

endmodule

// File: tb/tb_link_table_order_arbiter.sv
// -----------------------------------------------------------------------------
// tb_link_table_order_arbiter
//
// Self-checking bench for link_table_order_arbiter. Inputs are driven 1 time
// unit after the rising edge and outputs are sampled there as well. Expected
// grants come from a round-robin pointer kept as a plain integer; expected
// order fields and results come from the stimulus itself.
// -----------------------------------------------------------------------------
module tb_link_table_order_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TW = 8;
    localparam int TO = 16;
    localparam logic [N-1:0] ALL_ONES = '1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_busy;
    logic [2*N-1:0]      req_type;
    logic [TW*N-1:0]     req_table;
    logic [AW*N-1:0]     req_node;
    logic [DW*N-1:0]     req_data;
    logic [N-1:0]        rsp_valid;
    logic [N-1:0]        rsp_busy;
    logic [DW-1:0]       rsp_data;
    logic                rsp_timeout;
    logic                mgr_order_valid;
    logic                mgr_order_busy;
    logic [1:0]          mgr_order_type;
    logic [TW-1:0]       mgr_order_table;
    logic [AW-1:0]       mgr_order_node;
    logic [DW-1:0]       mgr_order_data;
    logic                mgr_dout_valid;
    logic                mgr_dout_busy;
    logic [DW-1:0]       mgr_dout_data;

    int n_checks = 0;
    int n_errors = 0;
    int model_ptr = 0;

    logic [1:0]    f_type  [N];
    logic [TW-1:0] f_table [N];
    logic [AW-1:0] f_node  [N];
    logic [DW-1:0] f_data  [N];

    always #5 clk = ~clk;

    link_table_order_arbiter #(
        .NUM_REQ        (N),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TABLE_WIDTH    (TW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_busy        (req_busy),
        .req_type        (req_type),
        .req_table       (req_table),
        .req_node        (req_node),
        .req_data        (req_data),
        .rsp_valid       (rsp_valid),
        .rsp_busy        (rsp_busy),
        .rsp_data        (rsp_data),
        .rsp_timeout     (rsp_timeout),
        .mgr_order_valid (mgr_order_valid),
        .mgr_order_busy  (mgr_order_busy),
        .mgr_order_type  (mgr_order_type),
        .mgr_order_table (mgr_order_table),
        .mgr_order_node  (mgr_order_node),
        .mgr_order_data  (mgr_order_data),
        .mgr_dout_valid  (mgr_dout_valid),
        .mgr_dout_busy   (mgr_dout_busy),
        .mgr_dout_data   (mgr_dout_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Round-robin reference: first set bit of mask at or after model_ptr.
    function automatic int model_grant(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[(model_ptr + k) % N]) return (model_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic rand_fields();
        for (int i = 0; i < N; i++) begin
            f_type[i]  = 2'($urandom);
            f_table[i] = TW'($urandom);
            f_node[i]  = AW'($urandom);
            f_data[i]  = DW'($urandom);
        end
    endtask

    task automatic drive_fields();
        for (int i = 0; i < N; i++) begin
            req_type [2*i  +: 2]  = f_type[i];
            req_table[TW*i +: TW] = f_table[i];
            req_node [AW*i +: AW] = f_node[i];
            req_data [DW*i +: DW] = f_data[i];
        end
    endtask

    // One complete order: grant, b cycles of manager order backpressure,
    // d cycles of manager latency (or a watchdog abort), r cycles of result
    // backpressure. Called at posedge+1 with the DUT in IDLE.
    task automatic run_txn(input logic [N-1:0] mask, input int b, input int d, input int r,
                           input bit to, input bit hold, input bit rnd,
                           input logic [DW-1:0] dval);
        int            g;
        logic [N-1:0]  oh;
        logic [N-1:0]  exp_busy;
        logic [1:0]    e_type;
        logic [TW-1:0] e_table;
        logic [AW-1:0] e_node;
        logic [DW-1:0] e_data;
        logic [DW-1:0] e_rsp;

        g = model_grant(mask);
        if (rnd) rand_fields();
        drive_fields();
        req_valid = mask;
        oh        = '0;
        oh[g]     = 1'b1;
        exp_busy  = ~oh;
        e_type    = f_type[g];
        e_table   = f_table[g];
        e_node    = f_node[g];
        e_data    = f_data[g];
        #1;
        check("req_busy_grant", req_busy, exp_busy);

        @(posedge clk); #1;
        if (!hold) req_valid = '0;
        check("order_valid", mgr_order_valid, 1);
        check("order_type", mgr_order_type, e_type);
        check("order_table", mgr_order_table, e_table);
        check("order_node", mgr_order_node, e_node);
        check("order_data", mgr_order_data, e_data);
        check("dout_busy_issue", mgr_dout_busy, 1);
        check("req_busy_issue", req_busy, ALL_ONES);

        mgr_order_busy = (b > 0);
        for (int i = 0; i < b; i++) begin
            rand_fields();
            drive_fields();
            req_valid = N'($urandom);
            @(posedge clk); #1;
            check("order_hold_valid", mgr_order_valid, 1);
            check("order_hold_node", mgr_order_node, e_node);
            check("order_hold_data", mgr_order_data, e_data);
        end
        mgr_order_busy = 1'b0;
        @(posedge clk); #1;
        check("order_drop", mgr_order_valid, 0);
        check("dout_busy_wait", mgr_dout_busy, 0);

        if (to) begin
            for (int k = b + 1; k < TO - 1; k++) begin
                @(posedge clk); #1;
                check("no_early_timeout", rsp_valid, 0);
            end
            @(posedge clk); #1;
            e_rsp = '0;
        end else begin
            for (int k = 0; k < d; k++) begin
                @(posedge clk); #1;
                check("no_early_rsp", rsp_valid, 0);
            end
            mgr_dout_valid = 1'b1;
            mgr_dout_data  = dval;
            @(posedge clk); #1;
            mgr_dout_valid = 1'b0;
            mgr_dout_data  = DW'($urandom);
            e_rsp          = dval;
        end
        check("rsp_valid", rsp_valid, oh);
        check("rsp_data", rsp_data, e_rsp);
        check("rsp_timeout", rsp_timeout, to);
        check("dout_busy_resp", mgr_dout_busy, 1);

        rsp_busy    = N'($urandom);
        rsp_busy[g] = (r > 0);
        for (int k = 0; k < r; k++) begin
            @(posedge clk); #1;
            check("rsp_hold_valid", rsp_valid, oh);
            check("rsp_hold_data", rsp_data, e_rsp);
            rsp_busy    = N'($urandom);
            rsp_busy[g] = (k < r - 1);
        end
        rsp_busy  = N'($urandom);
        rsp_busy[g] = 1'b0;
        req_valid = hold ? mask : '0;
        @(posedge clk); #1;
        rsp_busy = '0;
        check("rsp_release", rsp_valid, 0);
        check("idle_order_valid", mgr_order_valid, 0);
        model_ptr = (g + 1) % N;
    endtask

    // Hard stop so a stuck run still ends with a report.
    initial begin
        #500000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst_n          = 1'b0;
        req_valid      = '0;
        req_type       = '0;
        req_table      = '0;
        req_node       = '0;
        req_data       = '0;
        rsp_busy       = '0;
        mgr_order_busy = 1'b0;
        mgr_dout_valid = 1'b0;
        mgr_dout_data  = '0;
        for (int i = 0; i < N; i++) begin
            f_type[i] = '0; f_table[i] = '0; f_node[i] = '0; f_data[i] = '0;
        end

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_order_valid", mgr_order_valid, 0);
        check("rst_order_node", mgr_order_node, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_req_busy", req_busy, ALL_ONES);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // No requester: stays idle, all busy.
        req_valid = '0;
        #1;
        check("idle_req_busy", req_busy, ALL_ONES);
        @(posedge clk); #1;
        check("idle_no_grant", mgr_order_valid, 0);

        // Contention: all valid held, 8 orders -> 0,1,2,3,0,1,2,3.
        for (int t = 0; t < 8; t++) begin
            run_txn(4'b1111, 0, 1, 0, 1'b0, 1'b1, 1'b1, DW'($urandom));
        end
        req_valid = '0;

        // Single requester 2: READ table 3 node 5, result 0x00AB.
        f_type[2]  = 2'b11;
        f_table[2] = 8'd3;
        f_node[2]  = 16'd5;
        f_data[2]  = 16'h1234;
        run_txn(4'b0100, 0, 2, 0, 1'b0, 1'b0, 1'b0, 16'h00AB);

        // Fairness / wrap: grant 3, then 1001 -> 0, then 1001 -> 3.
        run_txn(4'b1000, 0, 0, 0, 1'b0, 1'b0, 1'b1, DW'($urandom));
        run_txn(4'b1001, 0, 0, 0, 1'b0, 1'b0, 1'b1, DW'($urandom));
        run_txn(4'b1001, 0, 0, 0, 1'b0, 1'b0, 1'b1, DW'($urandom));

        // Backpressure on both manager order and requester 1 result.
        run_txn(4'b0010, 5, 1, 4, 1'b0, 1'b0, 1'b1, DW'($urandom));

        // Watchdog abort: manager never answers.
        run_txn(4'b0100, 0, 0, 0, 1'b1, 1'b0, 1'b1, '0);
        run_txn(4'b0011, 3, 0, 2, 1'b1, 1'b0, 1'b1, '0);

        // Stale manager result in IDLE is consumed and dropped.
        mgr_dout_valid = 1'b1;
        mgr_dout_data  = 16'hDEAD;
        #1;
        check("stale_dout_busy", mgr_dout_busy, 0);
        @(posedge clk); #1;
        mgr_dout_valid = 1'b0;
        check("stale_no_rsp", rsp_valid, 0);

        // Randomized orders.
        for (int t = 0; t < 24; t++) begin
            run_txn(N'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 4),
                    $urandom_range(0, 3), ($urandom_range(0, 5) == 0),
                    1'($urandom_range(0, 1)), 1'b1, DW'($urandom));
        end
        req_valid = '0;

        // Reset in WAIT: everything back to zero, next grant from requester 0.
        if (model_ptr == 2) model_ptr = 2;
        rand_fields();
        drive_fields();
        req_valid = 4'b0100;
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        check("pre_rst_wait", mgr_order_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_order_valid", mgr_order_valid, 0);
        check("mid_rst_order_type", mgr_order_type, 0);
        check("mid_rst_order_table", mgr_order_table, 0);
        check("mid_rst_order_data", mgr_order_data, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rsp_data", rsp_data, 0);
        check("mid_rst_dout_busy", mgr_dout_busy, 0);
        rst_n     = 1'b1;
        model_ptr = 0;
        @(posedge clk); #1;
        run_txn(4'b1111, 0, 0, 0, 1'b0, 1'b0, 1'b1, DW'($urandom));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
